otg_hpi_bus_sequencer: RTL

//  Avalon-MM slave that turns one CPU access into one timed HPI bus cycle on the CY7C67200 OTG

---
 rtl/otg_hpi_bus_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/otg_hpi_bus_sequencer.sv
// otg_hpi_bus_sequencer
// Avalon-MM slave that turns one CPU access into one timed HPI bus cycle on the
// CY7C67200 OTG controller. Every HPI output comes straight from a flop.
// Phase order: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> RECOVER -> IDLE.
// Each *_CYC parameter must be >= 1 and < 2**CNT_W.
module otg_hpi_bus_sequencer #(
   parameter int unsigned SETUP_CYC   = 1,
   parameter int unsigned STROBE_CYC  = 4,
   parameter int unsigned HOLD_CYC    = 1,
   parameter int unsigned RECOVER_CYC = 2,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  avs_address,
   input  logic        avs_chipselect,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic        hpi_cs_n,
   output logic        hpi_rd_n,
   output logic        hpi_wr_n,
   output logic [1:0]  hpi_addr,
   output logic [15:0] hpi_data_out,
   output logic        hpi_data_oe,
   input  logic [15:0] hpi_data_in
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE,
      S_RECOVER
   } state_t;

   // Counter reload values: a phase of N cycles counts N-1 down to 0.
   localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             is_write_q;
   logic             cs_n_q;
   logic             rd_n_q;
   logic             wr_n_q;
   logic             oe_q;
   logic [1:0]       addr_q;
   logic [15:0]      data_out_q;
   logic [15:0]      readdata_q;

   logic req;
   logic cnt_zero;
   logic unused_wdata_hi;

   // Only the low half of the Avalon write word reaches the 16-bit HPI bus.
   assign unused_wdata_hi = ^avs_writedata[31:16];

   assign req      = avs_chipselect & (avs_read | avs_write);
   assign cnt_zero = (cnt_q == '0);

   // Phase sequencer; HPI outputs are loaded together with the state they belong to.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         is_write_q <= 1'b0;
         cs_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         oe_q       <= 1'b0;
         addr_q     <= 2'd0;
         data_out_q <= 16'd0;
         readdata_q <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  // Write takes priority when read and write arrive together.
                  is_write_q <= avs_write;
                  addr_q     <= avs_address;
                  data_out_q <= avs_writedata[15:0];
                  cs_n_q     <= 1'b0;
                  oe_q       <= avs_write;
                  cnt_q      <= SETUP_LD;
                  state_q    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt_zero) begin
                  rd_n_q  <= is_write_q;
                  wr_n_q  <= ~is_write_q;
                  cnt_q   <= STROBE_LD;
                  state_q <= S_STROBE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            S_STROBE: begin
               if (cnt_zero) begin
                  // Read data is taken on the edge that closes the strobe.
                  if (!is_write_q) begin
                     readdata_q <= hpi_data_in;
                  end
                  rd_n_q  <= 1'b1;
                  wr_n_q  <= 1'b1;
                  cnt_q   <= HOLD_LD;
                  state_q <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            S_HOLD: begin
               if (cnt_zero) begin
                  cs_n_q  <= 1'b1;
                  oe_q    <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            S_DONE: begin
               cnt_q   <= RECOVER_LD;
               state_q <= S_RECOVER;
            end
            S_RECOVER: begin
               if (cnt_zero) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign avs_waitrequest = (state_q != S_DONE);
   assign avs_readdata    = {16'd0, readdata_q};
   assign hpi_cs_n        = cs_n_q;
   assign hpi_rd_n        = rd_n_q;
   assign hpi_wr_n        = wr_n_q;
   assign hpi_addr        = addr_q;
   assign hpi_data_out    = data_out_q;
   assign hpi_data_oe     = oe_q;

endmodule
